pipe_hazard_unit: RTL and testbench

//   Hazard/forwarding controller for the pipelined successor of the single-cycle RV32 core.

---
 rtl/pipe_hazard_unit.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the pipelined RV32 core: tracks in-flight instructions,
// raises load-use stalls and branch flushes, selects EX operand forwarding sources.
module pipe_hazard_unit #(
  parameter int unsigned AW          = 5,
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned LOAD_STAGES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       id_valid_i,
  input  logic [AW-1:0]              id_rs1_i,
  input  logic [AW-1:0]              id_rs2_i,
  input  logic                       id_use_rs1_i,
  input  logic                       id_use_rs2_i,
  input  logic [AW-1:0]              id_rd_i,
  input  logic                       id_regwrite_i,
  input  logic                       id_memread_i,
  input  logic                       branch_taken_i,
  output logic                       stall_o,
  output logic                       flush_o,
  output logic                       pc_write_o,
  output logic                       ifid_write_o,
  output logic [$clog2(DEPTH)-1:0]   fwd_a_o,
  output logic [$clog2(DEPTH)-1:0]   fwd_b_o,
  output logic [CNT_W-1:0]           stall_cnt_o,
  output logic [CNT_W-1:0]           flush_cnt_o
);

  localparam int unsigned FW = $clog2(DEPTH);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          regwrite;
    logic          memread;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          use_rs1;
    logic          use_rs2;
  } entry_t;

  entry_t           entry_q [DEPTH];
  entry_t           entry0_d;
  logic [DEPTH-1:0] is_prod;
  logic [DEPTH-1:0] fwd_ok;
  logic             load_use;
  logic             load_window_hit;
  logic [FW-1:0]    fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // x0 is never a producer, so it can neither stall nor forward.
  always_comb begin
    is_prod = '0;
    fwd_ok  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      is_prod[k] = entry_q[k].valid && entry_q[k].regwrite && (entry_q[k].rd != '0);
      fwd_ok[k]  = is_prod[k] && !(entry_q[k].memread && (k <= LOAD_STAGES));
    end
  end

  always_comb begin
    load_use = 1'b0;
    for (int unsigned k = 0; k < LOAD_STAGES; k++) begin
      if (is_prod[k] && entry_q[k].memread &&
          ((id_use_rs1_i && (id_rs1_i == entry_q[k].rd)) ||
           (id_use_rs2_i && (id_rs2_i == entry_q[k].rd)))) begin
        load_use = 1'b1;
      end
    end
  end

  // A taken branch squashes the dependent anyway, so it overrides the stall.
  assign stall_o      = id_valid_i && !branch_taken_i && !rst_i && load_use;
  assign flush_o      = branch_taken_i && !rst_i;
  assign pc_write_o   = !stall_o;
  assign ifid_write_o = !stall_o;

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
      if (entry_q[0].valid && entry_q[0].use_rs1 && fwd_ok[k] &&
          (entry_q[k].rd == entry_q[0].rs1)) begin
        fwd_a = FW'(k);
      end
      if (entry_q[0].valid && entry_q[0].use_rs2 && fwd_ok[k] &&
          (entry_q[k].rd == entry_q[0].rs2)) begin
        fwd_b = FW'(k);
      end
    end
  end

  assign fwd_a_o = rst_i ? '0 : fwd_a;
  assign fwd_b_o = rst_i ? '0 : fwd_b;

  always_comb begin
    entry0_d = '0;
    if (id_valid_i && !stall_o && !flush_o) begin
      entry0_d.valid    = 1'b1;
      entry0_d.rd       = id_rd_i;
      entry0_d.regwrite = id_regwrite_i;
      entry0_d.memread  = id_memread_i;
      entry0_d.rs1      = id_rs1_i;
      entry0_d.rs2      = id_rs2_i;
      entry0_d.use_rs1  = id_use_rs1_i;
      entry0_d.use_rs2  = id_use_rs2_i;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < DEPTH; k++) entry_q[k] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      entry_q[0] <= entry0_d;
      for (int unsigned k = 1; k < DEPTH; k++) entry_q[k] <= entry_q[k-1];
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  // A load still inside the no-forward window must never feed entry0; the stall prevents it.
  always_comb begin
    load_window_hit = 1'b0;
    for (int unsigned k = 1; k <= LOAD_STAGES; k++) begin
      if (entry_q[0].valid && is_prod[k] && entry_q[k].memread &&
          ((entry_q[0].use_rs1 && (entry_q[0].rs1 == entry_q[k].rd)) ||
           (entry_q[0].use_rs2 && (entry_q[0].rs2 == entry_q[k].rd)))) begin
        load_window_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      load_use_covered: assert (!load_window_hit);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed scenarios plus randomized traffic against a
// history-based reference model (entry k = the instruction issued k+1 cycles ago).
module tb_pipe_hazard_unit;
  localparam int unsigned AW = 5, DEPTH = 3, LS = 1, CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_u1 = 1'b0, id_u2 = 1'b0, id_rw = 1'b0, id_mr = 1'b0, br = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic stall, flush, pc_write, ifid_write;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.AW(AW), .DEPTH(DEPTH), .LOAD_STAGES(LS), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_u1), .id_use_rs2_i(id_u2), .id_rd_i(id_rd), .id_regwrite_i(id_rw),
    .id_memread_i(id_mr), .branch_taken_i(br), .stall_o(stall), .flush_o(flush),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  typedef struct {
    bit valid; bit [4:0] rd; bit rw; bit mr; bit [4:0] rs1; bit [4:0] rs2; bit u1; bit u2;
  } inst_t;

  inst_t hist[$];  // hist[0] = most recently issued (ID->EX) instruction
  int m_scnt = 0, m_fcnt = 0;

  function automatic bit m_prod(int k);
    if (k >= hist.size()) return 0;
    return hist[k].valid && hist[k].rw && hist[k].rd != 0;
  endfunction

  function automatic bit m_stall();
    if (!id_valid || br || rst) return 0;
    for (int k = 0; k < LS; k++)
      if (m_prod(k) && hist[k].mr &&
          ((id_u1 && id_rs1 == hist[k].rd) || (id_u2 && id_rs2 == hist[k].rd))) return 1;
    return 0;
  endfunction

  function automatic int m_fwd(bit opb);
    bit [4:0] rs;
    if (rst || hist.size() == 0 || !hist[0].valid) return 0;
    if (!(opb ? hist[0].u2 : hist[0].u1)) return 0;
    rs = opb ? hist[0].rs2 : hist[0].rs1;
    for (int k = 1; k < DEPTH; k++)
      if (m_prod(k) && hist[k].rd == rs && !(hist[k].mr && k <= LS)) return k;
    return 0;
  endfunction

  task automatic tick();
    bit s, f;
    inst_t n;
    s = m_stall();
    f = br && !rst;
    @(posedge clk);
    if (rst) begin
      hist.delete();
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      n = '{valid: id_valid && !s && !f, rd: id_rd, rw: id_rw, mr: id_mr,
            rs1: id_rs1, rs2: id_rs2, u1: id_u1, u2: id_u2};
      hist.push_front(n);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      if (s && m_scnt < 3) m_scnt++;
      if (f && m_fcnt < 3) m_fcnt++;
    end
    #1;
  endtask

  task automatic set_id(input bit v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input bit u1, input bit u2, input bit rw,
                        input bit mr);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_u1 = u1; id_u2 = u2; id_rw = rw; id_mr = mr;
    #1;
  endtask

  task automatic idle(int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    br = 0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1; br = 1;
    tick(); tick();
    checks += 7;
    if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b want 0", flush); end
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
    if (pc_write !== 1'b1) begin errors++; $display("FAIL reset_pcw got %0b want 1", pc_write); end
    if (fwd_a !== 2'd0) begin errors++; $display("FAIL reset_fwd_a got %0d want 0", fwd_a); end
    if (fwd_b !== 2'd0) begin errors++; $display("FAIL reset_fwd_b got %0d want 0", fwd_b); end
    if (stall_cnt !== 2'd0) begin errors++; $display("FAIL reset_scnt got %0d want 0", stall_cnt); end
    if (flush_cnt !== 2'd0) begin errors++; $display("FAIL reset_fcnt got %0d want 0", flush_cnt); end
    rst = 0; br = 0;
    #1;
  endtask

  task automatic test_fwd_basic();
    idle(3);
    set_id(1, 5, 1, 2, 1, 1, 1, 0); tick();           // add x5,x1,x2
    set_id(1, 6, 5, 7, 1, 1, 1, 0);                   // add x6,x5,x7
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %0b want 0", stall); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    checks += 3;
    if (fwd_a !== 2'd1) begin errors++; $display("FAIL b2b_fwd_a got %0d want 1", fwd_a); end
    if (fwd_b !== 2'd0) begin errors++; $display("FAIL b2b_fwd_b got %0d want 0", fwd_b); end
    if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall2 got %0b want 0", stall); end
  endtask

  task automatic test_fwd_gap_youngest();
    idle(3);
    set_id(1, 5, 1, 2, 1, 1, 1, 0); tick();           // add x5
    set_id(0, 0, 0, 0, 0, 0, 0, 0); tick();           // nop
    set_id(1, 8, 1, 5, 1, 1, 1, 0); tick();           // sub x8,x1,x5
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    checks += 2;
    if (fwd_b !== 2'd2) begin errors++; $display("FAIL gap_fwd_b got %0d want 2", fwd_b); end
    if (fwd_a !== 2'd0) begin errors++; $display("FAIL gap_fwd_a got %0d want 0", fwd_a); end
    idle(3);
    set_id(1, 5, 1, 2, 1, 1, 1, 0); tick();
    set_id(1, 5, 3, 4, 1, 1, 1, 0); tick();
    set_id(1, 9, 5, 0, 1, 0, 1, 0); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (fwd_a !== 2'd1) begin errors++; $display("FAIL youngest_fwd_a got %0d want 1", fwd_a); end
  endtask

  task automatic test_load_use();
    idle(3);
    set_id(1, 5, 2, 0, 1, 0, 1, 1); tick();           // lw x5,0(x2)
    set_id(1, 6, 5, 5, 1, 1, 1, 0);                   // add x6,x5,x5
    checks += 3;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", stall); end
    if (pc_write !== 1'b0) begin errors++; $display("FAIL lu_pcw got %0b want 0", pc_write); end
    if (ifid_write !== 1'b0) begin errors++; $display("FAIL lu_ifid got %0b want 0", ifid_write); end
    tick();
    checks += 2;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall2 got %0b want 0", stall); end
    if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_pcw2 got %0b want 1", pc_write); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    checks += 3;
    if (fwd_a !== 2'd2) begin errors++; $display("FAIL lu_fwd_a got %0d want 2", fwd_a); end
    if (fwd_b !== 2'd2) begin errors++; $display("FAIL lu_fwd_b got %0d want 2", fwd_b); end
    if (stall_cnt !== 2'd1) begin errors++; $display("FAIL lu_scnt got %0d want 1", stall_cnt); end
  endtask

  task automatic test_flush_over_stall();
    idle(3);
    set_id(1, 5, 2, 0, 1, 0, 1, 1); tick();           // lw x5
    set_id(1, 6, 5, 5, 1, 1, 1, 0); br = 1; #1;       // dependent + taken branch
    checks += 3;
    if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %0b want 0", stall); end
    if (flush !== 1'b1) begin errors++; $display("FAIL fl_flush got %0b want 1", flush); end
    if (pc_write !== 1'b1) begin errors++; $display("FAIL fl_pcw got %0b want 1", pc_write); end
    tick();
    br = 0;
    set_id(1, 7, 6, 0, 1, 0, 1, 0); tick();           // reads x6: only forwardable if not squashed
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    checks += 2;
    if (fwd_a !== 2'd0) begin errors++; $display("FAIL fl_bubble_fwd got %0d want 0", fwd_a); end
    if (flush_cnt !== 2'd1) begin errors++; $display("FAIL fl_fcnt got %0d want 1", flush_cnt); end
  endtask

  task automatic test_x0_and_saturation();
    idle(3);
    set_id(1, 0, 2, 0, 1, 0, 1, 1); tick();           // lw x0
    set_id(1, 1, 0, 0, 1, 1, 1, 0);                   // add x1,x0,x0
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %0b want 0", stall); end
    tick();
    set_id(1, 2, 0, 0, 1, 1, 1, 0); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    checks += 2;
    if (fwd_a !== 2'd0) begin errors++; $display("FAIL x0_fwd_a got %0d want 0", fwd_a); end
    if (fwd_b !== 2'd0) begin errors++; $display("FAIL x0_fwd_b got %0d want 0", fwd_b); end
    for (int i = 0; i < 5; i++) begin
      set_id(1, 5, 2, 0, 1, 0, 1, 1); tick();
      set_id(1, 6, 0, 5, 0, 1, 1, 0);
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall%0d got %0b want 1", i, stall); end
      tick();
      idle(1);
    end
    checks++;
    if (stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_scnt got %0d want 3", stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    idle(3);
    set_id(1, 5, 2, 0, 1, 0, 1, 1); tick();
    set_id(1, 6, 5, 0, 1, 0, 1, 0);
    rst = 1; #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", stall); end
    tick();
    rst = 0; #1;
    checks += 3;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_after_stall got %0b want 0", stall); end
    if (stall_cnt !== 2'd0) begin errors++; $display("FAIL rst_scnt got %0d want 0", stall_cnt); end
    if (flush_cnt !== 2'd0) begin errors++; $display("FAIL rst_fcnt got %0d want 0", flush_cnt); end
  endtask

  task automatic test_random();
    idle(3);
    for (int c = 0; c < 400; c++) begin
      set_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4);
      br = ($urandom_range(0, 9) == 0);
      #1;
      checks += 7;
      if (stall !== m_stall()) begin
        errors++; $display("FAIL rnd_stall c%0d got %0b want %0b", c, stall, m_stall());
      end
      if (flush !== br) begin errors++; $display("FAIL rnd_flush c%0d got %0b want %0b", c, flush, br); end
      if (pc_write !== !m_stall()) begin
        errors++; $display("FAIL rnd_pcw c%0d got %0b want %0b", c, pc_write, !m_stall());
      end
      if (fwd_a !== 2'(m_fwd(0))) begin
        errors++; $display("FAIL rnd_fwd_a c%0d got %0d want %0d", c, fwd_a, m_fwd(0));
      end
      if (fwd_b !== 2'(m_fwd(1))) begin
        errors++; $display("FAIL rnd_fwd_b c%0d got %0d want %0d", c, fwd_b, m_fwd(1));
      end
      if (stall_cnt !== 2'(m_scnt)) begin
        errors++; $display("FAIL rnd_scnt c%0d got %0d want %0d", c, stall_cnt, m_scnt);
      end
      if (flush_cnt !== 2'(m_fcnt)) begin
        errors++; $display("FAIL rnd_fcnt c%0d got %0d want %0d", c, flush_cnt, m_fcnt);
      end
      tick();
    end
    br = 0;
  endtask

  initial begin
    test_reset();
    test_fwd_basic();
    test_fwd_gap_youngest();
    test_load_use();
    test_flush_over_stall();
    test_x0_and_saturation();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
